// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the mips run controller: FSM states, run status codes
// and the 97-bit commit-trace entry.
package cpu_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HALT    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_LOSS    = 2'b11
  } status_e;

  localparam logic TK_GRF = 1'b0;
  localparam logic TK_DM  = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  localparam int TRACE_W = $bits(trace_t);

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bench-facing bundle of the run controller: core commit stream, run
// control/status and the trace drain port.
interface cpu_run_ctrl_if #(parameter int CNT_W = 32);
  logic             start;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             grf_we;
  logic [4:0]       grf_addr;
  logic [31:0]      grf_data;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_data;
  logic             core_reset;
  logic             running;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_cnt;
  logic             tr_valid;
  logic             tr_ready;
  logic             tr_kind;
  logic [31:0]      tr_pc;
  logic [31:0]      tr_addr;
  logic [31:0]      tr_data;

  modport master (
    output start, pc, instr, grf_we, grf_addr, grf_data, dm_we, dm_addr, dm_data, tr_ready,
    input  core_reset, running, done, status, cycle_cnt, tr_valid, tr_kind, tr_pc, tr_addr, tr_data
  );

  modport slave (
    input  start, pc, instr, grf_we, grf_addr, grf_data, dm_we, dm_addr, dm_data, tr_ready,
    output core_reset, running, done, status, cycle_cnt, tr_valid, tr_kind, tr_pc, tr_addr, tr_data
  );
endinterface

// File: rtl/cpu_run_ctrl_trace_fifo.sv
// First-word-fall-through FIFO for commit-trace entries. A push into a full
// FIFO is taken only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 97
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  r_wp, r_rp;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push, w_do_pop;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + PTR_ONE;
      if (w_do_pop)  r_rp <= r_rp + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which slots hold valid data.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rp[AW-1:0]];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle mips core: sequences core reset,
// counts RUN cycles, ends on halt or timeout and captures GRF/DM writes.
module cpu_run_ctrl
  import cpu_tb_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          CNT_W      = 32,
  parameter int          RST_CYCLES = 2,
  parameter int          MAX_CYCLES = 10000,
  parameter logic [31:0] HALT_INSTR = 32'h1000ffff
) (
  input  logic           clk,
  input  logic           reset,
  cpu_run_ctrl_if.slave  bus
);
  localparam int               RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e           r_state, w_state_nx;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  status_e          r_status, w_exit_code;
  logic             w_clear, w_cap_en, w_exit;
  logic             w_core_reset, w_running, w_done;
  logic             w_grf_ev, w_dm_ev, w_push_req, w_pop, w_loss;
  logic             w_full, w_empty;
  trace_t           w_push_entry, w_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nx   = r_state;
    w_core_reset = 1'b1;
    w_running    = 1'b0;
    w_done       = 1'b0;
    w_clear      = 1'b0;
    w_cap_en     = 1'b0;
    w_exit       = 1'b0;
    w_exit_code  = ST_NONE;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx = RST;
          w_clear    = 1'b1;
        end
      end
      RST: begin
        if (r_rst_cnt == RC_LAST) w_state_nx = RUN;
      end
      RUN: begin
        w_core_reset = 1'b0;
        w_running    = 1'b1;
        w_cap_en     = 1'b1;
        if (bus.instr == HALT_INSTR) begin
          w_state_nx  = DRAIN;
          w_exit      = 1'b1;
          w_exit_code = ST_HALT;
        end else if (r_cycle_cnt == CNT_LAST) begin
          w_state_nx  = DRAIN;
          w_exit      = 1'b1;
          w_exit_code = ST_TIMEOUT;
        end
      end
      DRAIN: begin
        if (w_empty) w_state_nx = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_state_nx = RST;
          w_clear    = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_grf_ev   = bus.grf_we && (bus.grf_addr != 5'd0);
  assign w_dm_ev    = bus.dm_we;
  assign w_push_req = w_cap_en && (w_grf_ev || w_dm_ev);
  assign w_pop      = !w_empty && bus.tr_ready;
  // A simultaneous GRF+DM write keeps only the GRF event, which is itself a loss.
  assign w_loss     = w_cap_en && ((w_grf_ev && w_dm_ev) || (w_push_req && w_full && !w_pop));

  always_comb begin
    w_push_entry = '{kind: TK_DM, pc: bus.pc, addr: bus.dm_addr, data: bus.dm_data};
    if (w_grf_ev)
      w_push_entry = '{kind: TK_GRF, pc: bus.pc, addr: {27'd0, bus.grf_addr}, data: bus.grf_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_cnt   <= '0;
      r_cycle_cnt <= '0;
      r_status    <= ST_NONE;
    end else if (w_clear) begin
      r_rst_cnt   <= '0;
      r_cycle_cnt <= '0;
      r_status    <= ST_NONE;
    end else begin
      if (r_state == RST) r_rst_cnt <= r_rst_cnt + 1'b1;
      if (w_running)      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_loss)                                r_status <= ST_LOSS;
      else if (w_exit && (r_status != ST_LOSS))  r_status <= w_exit_code;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (TRACE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_clear),
    .i_push  (w_push_req),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.core_reset = w_core_reset;
  assign bus.running    = w_running;
  assign bus.done       = w_done;
  assign bus.status     = r_status;
  assign bus.cycle_cnt  = r_cycle_cnt;
  assign bus.tr_valid   = !w_empty;
  assign bus.tr_kind    = w_head.kind;
  assign bus.tr_pc      = w_head.pc;
  assign bus.tr_addr    = w_head.addr;
  assign bus.tr_data    = w_head.data;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset, start sequencing, trace capture,
// halt/timeout exits, FIFO overflow, simultaneous writes and mid-run reset.
module tb_cpu_run_ctrl;
  import cpu_tb_pkg::*;

  localparam logic [31:0] HALT = 32'h1000ffff;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  cpu_run_ctrl_if #(.CNT_W(32)) bus ();

  cpu_run_ctrl #(
    .DEPTH      (4),
    .CNT_W      (32),
    .RST_CYCLES (2),
    .MAX_CYCLES (20),
    .HALT_INSTR (HALT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.pc       = '0;
    bus.instr    = '0;
    bus.grf_we   = 1'b0;
    bus.grf_addr = '0;
    bus.grf_data = '0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_data  = '0;
  endtask

  task automatic grf_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    bus.grf_we   = 1'b1;
    bus.grf_addr = a;
    bus.grf_data = d;
    bus.dm_we    = 1'b0;
    bus.pc       = p;
  endtask

  task automatic chk_entry(input string tag, input logic k, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] d);
    check({tag, "_valid"}, {31'd0, bus.tr_valid}, 32'd1);
    check({tag, "_kind"},  {31'd0, bus.tr_kind},  {31'd0, k});
    check({tag, "_pc"},    bus.tr_pc,   p);
    check({tag, "_addr"},  bus.tr_addr, a);
    check({tag, "_data"},  bus.tr_data, d);
  endtask

  // Pulse start, walk the two RST cycles, and stop at the first RUN cycle.
  task automatic start_run(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_rst1_core_reset"}, {31'd0, bus.core_reset}, 32'd1);
    check({tag, "_rst1_running"},    {31'd0, bus.running},    32'd0);
    check({tag, "_rst1_done"},       {31'd0, bus.done},       32'd0);
    check({tag, "_rst1_status"},     {30'd0, bus.status},     32'd0);
    check({tag, "_rst1_cnt"},        bus.cycle_cnt,           32'd0);
    tick();
    check({tag, "_rst2_core_reset"}, {31'd0, bus.core_reset}, 32'd1);
    tick();
    check({tag, "_run_core_reset"},  {31'd0, bus.core_reset}, 32'd0);
    check({tag, "_run_running"},     {31'd0, bus.running},    32'd1);
    check({tag, "_run_cnt0"},        bus.cycle_cnt,           32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.tr_ready = 1'b0;
    idle_inputs();
    tick();
    check("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
    check("rst_running",    {31'd0, bus.running},    32'd0);
    check("rst_done",       {31'd0, bus.done},       32'd0);
    check("rst_status",     {30'd0, bus.status},     32'd0);
    check("rst_cnt",        bus.cycle_cnt,           32'd0);
    check("rst_tr_valid",   {31'd0, bus.tr_valid},   32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_hold_core_reset", {31'd0, bus.core_reset}, 32'd1);
    check("idle_hold_running",    {31'd0, bus.running},    32'd0);

    // Basic capture: $8 write, ignored $0 write, DM write.
    start_run("t1");
    bus.tr_ready = 1'b1;
    grf_write(5'd8, 32'h12345678, 32'h3000);
    tick();
    check("t1_cnt1", bus.cycle_cnt, 32'd1);
    chk_entry("t2_e0", TK_GRF, 32'h3000, 32'd8, 32'h12345678);
    grf_write(5'd0, 32'd5, 32'h3004);
    tick();
    check("t2_r0_ignored", {31'd0, bus.tr_valid}, 32'd0);
    bus.grf_we  = 1'b0;
    bus.dm_we   = 1'b1;
    bus.dm_addr = 32'h4;
    bus.dm_data = 32'habcd;
    bus.pc      = 32'h3008;
    tick();
    chk_entry("t2_e1", TK_DM, 32'h3008, 32'h4, 32'habcd);
    idle_inputs();
    tick();
    check("t2_only2", {31'd0, bus.tr_valid}, 32'd0);

    // Halt in the 7th RUN cycle with three entries pending and drain stalled.
    bus.tr_ready = 1'b0;
    grf_write(5'd9, 32'h11, 32'h3010);
    tick();
    grf_write(5'd10, 32'h22, 32'h3014);
    tick();
    bus.grf_we  = 1'b0;
    bus.instr   = HALT;
    bus.dm_we   = 1'b1;
    bus.dm_addr = 32'h8;
    bus.dm_data = 32'h33;
    bus.pc      = 32'h3018;
    tick();
    check("t3_drain_running",    {31'd0, bus.running},    32'd0);
    check("t3_drain_core_reset", {31'd0, bus.core_reset}, 32'd1);
    check("t3_drain_done",       {31'd0, bus.done},       32'd0);
    check("t3_drain_status",     {30'd0, bus.status},     32'd1);
    check("t3_drain_cnt",        bus.cycle_cnt,           32'd7);
    chk_entry("t3_c0", TK_GRF, 32'h3010, 32'd9, 32'h11);
    idle_inputs();
    grf_write(5'd5, 32'h55, 32'h301c);
    tick();
    chk_entry("t3_c0_stable", TK_GRF, 32'h3010, 32'd9, 32'h11);
    idle_inputs();
    bus.tr_ready = 1'b1;
    tick();
    chk_entry("t3_c1", TK_GRF, 32'h3014, 32'd10, 32'h22);
    tick();
    chk_entry("t3_c2", TK_DM, 32'h3018, 32'h8, 32'h33);
    tick();
    check("t3_empty",        {31'd0, bus.tr_valid}, 32'd0);
    check("t3_done_not_yet", {31'd0, bus.done},     32'd0);
    tick();
    check("t3_done",   {31'd0, bus.done},   32'd1);
    check("t3_status", {30'd0, bus.status}, 32'd1);
    check("t3_cnt",    bus.cycle_cnt,       32'd7);
    check("t3_no_drain_capture", {31'd0, bus.tr_valid}, 32'd0);

    // Timeout after 20 RUN cycles; a start pulse mid-run is ignored.
    start_run("t4");
    for (int i = 0; i < 20; i++) begin
      bus.start = (i == 5);
      tick();
      if (i == 5)  check("t4_start_ignored_cnt", bus.cycle_cnt, 32'd6);
      if (i == 18) check("t4_still_running", {31'd0, bus.running}, 32'd1);
    end
    bus.start = 1'b0;
    check("t4_left_run", {31'd0, bus.running}, 32'd0);
    tick();
    check("t4_done",   {31'd0, bus.done},   32'd1);
    check("t4_status", {30'd0, bus.status}, 32'd2);
    check("t4_cnt",    bus.cycle_cnt,       32'd20);

    // Halt on the last allowed cycle wins over timeout.
    start_run("tp");
    for (int i = 0; i < 20; i++) begin
      bus.instr = (i == 19) ? HALT : 32'd0;
      tick();
    end
    bus.instr = '0;
    tick();
    check("tp_done",   {31'd0, bus.done},   32'd1);
    check("tp_status", {30'd0, bus.status}, 32'd1);
    check("tp_cnt",    bus.cycle_cnt,       32'd20);

    // Overflow: six writes into a 4-deep FIFO with no drain.
    start_run("t5");
    bus.tr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      grf_write(5'(i + 1), 32'h100 + 32'(i), 32'h3000 + 32'(4 * i));
      tick();
      if (i == 3) check("t5_no_loss_yet", {30'd0, bus.status}, 32'd0);
      if (i == 4) check("t5_loss",        {30'd0, bus.status}, 32'd3);
    end
    idle_inputs();
    bus.instr = HALT;
    tick();
    check("t5_halt_keeps_loss", {30'd0, bus.status}, 32'd3);
    bus.instr = '0;
    bus.tr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_entry($sformatf("t5_e%0d", k), TK_GRF, 32'h3000 + 32'(4 * k), 32'(k + 1), 32'h100 + 32'(k));
      tick();
    end
    check("t5_only4", {31'd0, bus.tr_valid}, 32'd0);
    tick();
    check("t5_done",   {31'd0, bus.done},   32'd1);
    check("t5_status", {30'd0, bus.status}, 32'd3);

    // Push and pop in the same cycle while full: nothing lost.
    start_run("t6");
    bus.tr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      grf_write(5'(11 + i), 32'h200 + 32'(i), 32'h3100 + 32'(4 * i));
      tick();
    end
    bus.tr_ready = 1'b1;
    grf_write(5'd15, 32'h204, 32'h3110);
    tick();
    bus.tr_ready = 1'b0;
    idle_inputs();
    bus.instr = HALT;
    tick();
    check("t6_status_halt", {30'd0, bus.status}, 32'd1);
    bus.instr = '0;
    bus.tr_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk_entry($sformatf("t6_e%0d", k), TK_GRF, 32'h3100 + 32'(4 * k), 32'(11 + k), 32'h200 + 32'(k));
      tick();
    end
    check("t6_empty", {31'd0, bus.tr_valid}, 32'd0);
    tick();
    check("t6_done",   {31'd0, bus.done},   32'd1);
    check("t6_status", {30'd0, bus.status}, 32'd1);

    // GRF and DM write in one cycle: only the GRF entry, loss flagged.
    start_run("t7");
    bus.tr_ready = 1'b1;
    grf_write(5'd3, 32'h77, 32'h3200);
    bus.dm_we   = 1'b1;
    bus.dm_addr = 32'h10;
    bus.dm_data = 32'h88;
    tick();
    chk_entry("t7_grf", TK_GRF, 32'h3200, 32'd3, 32'h77);
    check("t7_loss", {30'd0, bus.status}, 32'd3);
    idle_inputs();
    tick();
    check("t7_no_dm", {31'd0, bus.tr_valid}, 32'd0);
    bus.instr = HALT;
    tick();
    bus.instr = '0;
    tick();
    check("t7_done",   {31'd0, bus.done},   32'd1);
    check("t7_status", {30'd0, bus.status}, 32'd3);

    // Reset mid-run with two entries queued, then a clean run.
    start_run("t8");
    bus.tr_ready = 1'b0;
    grf_write(5'd20, 32'h1, 32'h3300);
    tick();
    grf_write(5'd21, 32'h2, 32'h3304);
    tick();
    idle_inputs();
    check("t8_queued", {31'd0, bus.tr_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t8_async_tr_valid",   {31'd0, bus.tr_valid},   32'd0);
    check("t8_async_cnt",        bus.cycle_cnt,           32'd0);
    check("t8_async_core_reset", {31'd0, bus.core_reset}, 32'd1);
    tick();
    check("t8_idle_running", {31'd0, bus.running}, 32'd0);
    check("t8_idle_status",  {30'd0, bus.status},  32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("t8_idle_no_start", {31'd0, bus.core_reset}, 32'd1);
    check("t8_idle_tr_valid", {31'd0, bus.tr_valid},   32'd0);
    start_run("t8b");
    bus.tr_ready = 1'b1;
    grf_write(5'd22, 32'h99, 32'h3400);
    tick();
    chk_entry("t8_clean", TK_GRF, 32'h3400, 32'd22, 32'h99);
    idle_inputs();
    bus.instr = HALT;
    tick();
    bus.instr = '0;
    tick();
    check("t8_done",   {31'd0, bus.done},   32'd1);
    check("t8_status", {30'd0, bus.status}, 32'd1);
    check("t8_cnt",    bus.cycle_cnt,       32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
